spi_shift_engine: RTL

//  Byte-level SPI shift engine between the SPI register block and the pins.

---
 rtl/spi_shift_engine_if.sv | 28 ++
 rtl/spi_shift_engine.sv | 107 ++++++++++
 2 files changed

// File: rtl/spi_shift_engine_if.sv
// Register-block / pin-side signal bundle for spi_shift_engine.
// The engine connects through the slave modport; the register block or bench uses master.
interface spi_shift_engine_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  cs_i;
    logic                  high_pulse_i;
    logic                  low_pulse_i;
    logic                  transmit_i;
    logic [DATA_WIDTH-1:0] transmit_data_i;
    logic                  busy_o;
    logic [DATA_WIDTH-1:0] received_data_o;
    logic                  transmit_done_o;
    logic                  spi_cs_o;
    logic                  spi_clk_o;
    logic                  spi_mosi_o;
    logic                  spi_miso_i;

    modport slave (
        input  cs_i, high_pulse_i, low_pulse_i, transmit_i, transmit_data_i, spi_miso_i,
        output busy_o, received_data_o, transmit_done_o, spi_cs_o, spi_clk_o, spi_mosi_o
    );

    modport master (
        output cs_i, high_pulse_i, low_pulse_i, transmit_i, transmit_data_i, spi_miso_i,
        input  busy_o, received_data_o, transmit_done_o, spi_cs_o, spi_clk_o, spi_mosi_o
    );
endinterface

// File: rtl/spi_shift_engine.sv
// Byte-level SPI master shift engine: MSB-first, CPOL/CPHA selectable, SCK edges
// timed by external prescaler strobes, registered outputs and a one-cycle done pulse.
module spi_shift_engine #(
    parameter int DATA_WIDTH = 8,
    parameter bit CPOL       = 1'b0,
    parameter bit CPHA       = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    spi_shift_engine_if.slave bus
);
    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]            state;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [DATA_WIDTH-1:0] rx_q;
    logic [CNT_W-1:0]      bit_cnt;
    logic [CNT_W-1:0]      cnt_inc;
    logic                  busy_q;
    logic                  done_q;
    logic                  cs_n_q;
    logic                  sck_q;
    logic                  mosi_q;

    assign cnt_inc = bit_cnt + CNT_W'(1);

    assign bus.busy_o          = busy_q;
    assign bus.received_data_o = rx_q;
    assign bus.transmit_done_o = done_q;
    assign bus.spi_cs_o        = cs_n_q;
    assign bus.spi_clk_o       = sck_q;
    assign bus.spi_mosi_o      = mosi_q;

    // NOTE: every register here is state, so all updates use <= and all of them
    // (shift register included) take a defined value on the asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= ST_IDLE;
            shift_reg <= '0;
            rx_q      <= '0;
            bit_cnt   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            sck_q     <= CPOL;
            mosi_q    <= 1'b0;
        end else begin
            cs_n_q <= ~bus.cs_i;
            done_q <= 1'b0;

            case (state)
                ST_IDLE: begin
                    sck_q <= CPOL;
                    if (bus.transmit_i) begin
                        shift_reg <= bus.transmit_data_i;
                        bit_cnt   <= '0;
                        busy_q    <= 1'b1;
                        state     <= ST_SETUP;
                        if (!CPHA) mosi_q <= bus.transmit_data_i[DATA_WIDTH-1];
                    end
                end

                // A full half-period of MOSI setup precedes the first leading edge.
                ST_SETUP: begin
                    if (bus.low_pulse_i) state <= ST_SHIFT;
                end

                // Trailing wins if both strobes ever coincide.
                ST_SHIFT: begin
                    if (bus.low_pulse_i) begin
                        sck_q   <= CPOL;
                        bit_cnt <= cnt_inc;
                        if (CPHA) begin
                            shift_reg <= {shift_reg[DATA_WIDTH-2:0], bus.spi_miso_i};
                        end else if (cnt_inc != LAST_CNT) begin
                            mosi_q <= shift_reg[DATA_WIDTH-1];
                        end
                        if (cnt_inc == LAST_CNT) state <= ST_DONE;
                    end else if (bus.high_pulse_i) begin
                        sck_q <= ~CPOL;
                        if (CPHA) begin
                            mosi_q <= shift_reg[DATA_WIDTH-1];
                        end else begin
                            shift_reg <= {shift_reg[DATA_WIDTH-2:0], bus.spi_miso_i};
                        end
                    end
                end

                ST_DONE: begin
                    rx_q   <= shift_reg;
                    done_q <= 1'b1;
                    sck_q  <= CPOL;
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
